// File: rtl/alu19_pkg.sv
// Shared constants, op encoding and bit-manipulation helpers for the 19-bit ALU.
`timescale 1ns/1ps
package alu19_pkg;

    localparam int          W       = 19;
    localparam logic [18:0] SMAX    = 19'h3FFFF;
    localparam logic [18:0] SMIN    = 19'h40000;
    localparam logic [18:0] ENC_KEY = 19'h0C6FE;
    localparam int          ENC_ROT = 3;

    // Decoded operation, listed in select-priority order (ADD highest).
    typedef enum logic [3:0] {
        OP_NONE,
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_DIV,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_NOT,
        OP_INC,
        OP_DEC,
        OP_FFT,
        OP_ENC,
        OP_DNC,
        OP_TNF
    } op_e;

    function automatic logic [W-1:0] bit_reverse(input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            r[i] = x[W-1-i];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x);
        return (x << ENC_ROT) | (x >> (W - ENC_ROT));
    endfunction

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x);
        return (x >> ENC_ROT) | (x << (W - ENC_ROT));
    endfunction

endpackage

// File: rtl/alu19_sdiv.sv
// Combinational signed divider: quotient truncated toward zero, with
// divide-by-zero and the single signed-overflow case flagged.
`timescale 1ns/1ps
module alu19_sdiv
    import alu19_pkg::*;
(
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         ovf
);

    logic [W-1:0] abs_a;
    logic [W-1:0] abs_b;
    logic [W-1:0] safe_b;
    logic [W-1:0] q_mag;
    logic         q_neg;
    logic         div_zero;

    // Magnitudes fit unsigned in W bits, including 2^18 for the most negative value.
    assign abs_a    = dividend[W-1] ? (~dividend + 1'b1) : dividend;
    assign abs_b    = divisor[W-1]  ? (~divisor + 1'b1)  : divisor;
    assign div_zero = (divisor == '0);
    assign safe_b   = div_zero ? {{(W-1){1'b0}}, 1'b1} : abs_b;
    assign q_mag    = abs_a / safe_b;
    assign q_neg    = dividend[W-1] ^ divisor[W-1];

    // Pick the error results first, otherwise apply the sign to the magnitude quotient.
    always_comb begin
        quotient = q_neg ? (~q_mag + 1'b1) : q_mag;
        ovf      = 1'b0;
        if (div_zero) begin
            quotient = 19'h7FFFF;
            ovf      = 1'b1;
        end else if (dividend == SMIN && divisor == 19'h7FFFF) begin
            quotient = SMIN;
            ovf      = 1'b1;
        end
    end

endmodule

// File: rtl/alu_19bit.sv
// 19-bit two's-complement ALU: priority strobe decoder, result mux and
// a one-cycle output register for the result and overflow flag.
`timescale 1ns/1ps
module alu_19bit
    import alu19_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  AC,
    input  logic [W-1:0]  DR,
    input  logic          ADD,
    input  logic          SUB,
    input  logic          MUL,
    input  logic          DIV,
    input  logic          AND,
    input  logic          OR,
    input  logic          XOR,
    input  logic          NOT,
    input  logic          INC,
    input  logic          DEC,
    input  logic          FFT,
    input  logic          ENC,
    input  logic          DNC,
    input  logic          TNF,
    output logic [W-1:0]  ALU_OP,
    output logic          OVF_FLAG
);

    op_e                   op_sel;
    logic [W-1:0]          sum;
    logic [W-1:0]          diff;
    logic signed [2*W-1:0] prod;
    logic [W-1:0]          div_q;
    logic                  div_ovf;
    logic                  mul_ovf;
    logic [W-1:0]          next_op;
    logic                  next_ovf;

    assign sum     = AC + DR;
    assign diff    = AC - DR;
    assign prod    = $signed(AC) * $signed(DR);
    assign mul_ovf = (prod != {{W{prod[W-1]}}, prod[W-1:0]});

    alu19_sdiv u_sdiv (
        .dividend (AC),
        .divisor  (DR),
        .quotient (div_q),
        .ovf      (div_ovf)
    );

    // Fixed-priority decode of the strobes into a single operation.
    always_comb begin
        op_sel = OP_NONE;
        if      (ADD) op_sel = OP_ADD;
        else if (SUB) op_sel = OP_SUB;
        else if (MUL) op_sel = OP_MUL;
        else if (DIV) op_sel = OP_DIV;
        else if (AND) op_sel = OP_AND;
        else if (OR)  op_sel = OP_OR;
        else if (XOR) op_sel = OP_XOR;
        else if (NOT) op_sel = OP_NOT;
        else if (INC) op_sel = OP_INC;
        else if (DEC) op_sel = OP_DEC;
        else if (FFT) op_sel = OP_FFT;
        else if (ENC) op_sel = OP_ENC;
        else if (DNC) op_sel = OP_DNC;
        else if (TNF) op_sel = OP_TNF;
    end

    // Select the result and overflow for the decoded operation; idle loads zero.
    always_comb begin
        next_op  = '0;
        next_ovf = 1'b0;
        case (op_sel)
            OP_ADD: begin
                next_op  = sum;
                next_ovf = (AC[W-1] == DR[W-1]) && (sum[W-1] != AC[W-1]);
            end
            OP_SUB: begin
                next_op  = diff;
                next_ovf = (AC[W-1] != DR[W-1]) && (diff[W-1] != AC[W-1]);
            end
            OP_MUL: begin
                next_op  = prod[W-1:0];
                next_ovf = mul_ovf;
            end
            OP_DIV: begin
                next_op  = div_q;
                next_ovf = div_ovf;
            end
            OP_AND: next_op = AC & DR;
            OP_OR:  next_op = AC | DR;
            OP_XOR: next_op = AC ^ DR;
            OP_NOT: next_op = ~AC;
            OP_INC: begin
                next_op  = AC + 1'b1;
                next_ovf = (AC == SMAX);
            end
            OP_DEC: begin
                next_op  = AC - 1'b1;
                next_ovf = (AC == SMIN);
            end
            OP_FFT: next_op = bit_reverse(AC);
            OP_ENC: next_op = rotl(AC) ^ ENC_KEY;
            OP_DNC: next_op = rotr(AC ^ ENC_KEY);
            OP_TNF: begin
                next_op  = ~AC + 1'b1;
                next_ovf = (AC == SMIN);
            end
            default: begin
                next_op  = '0;
                next_ovf = 1'b0;
            end
        endcase
    end

    // Output register; reset clears it immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALU_OP   <= '0;
            OVF_FLAG <= 1'b0;
        end else begin
            ALU_OP   <= next_op;
            OVF_FLAG <= next_ovf;
        end
    end

endmodule

// File: tb/tb_alu_19bit.sv
// Directed-vector bench for alu_19bit with hand-computed expected values.
`timescale 1ns/1ps
module tb_alu_19bit;

    localparam logic [13:0] K_NONE = 14'd0;
    localparam logic [13:0] K_ADD  = 14'b10000000000000;
    localparam logic [13:0] K_SUB  = 14'b01000000000000;
    localparam logic [13:0] K_MUL  = 14'b00100000000000;
    localparam logic [13:0] K_DIV  = 14'b00010000000000;
    localparam logic [13:0] K_AND  = 14'b00001000000000;
    localparam logic [13:0] K_OR   = 14'b00000100000000;
    localparam logic [13:0] K_XOR  = 14'b00000010000000;
    localparam logic [13:0] K_NOT  = 14'b00000001000000;
    localparam logic [13:0] K_INC  = 14'b00000000100000;
    localparam logic [13:0] K_DEC  = 14'b00000000010000;
    localparam logic [13:0] K_FFT  = 14'b00000000001000;
    localparam logic [13:0] K_ENC  = 14'b00000000000100;
    localparam logic [13:0] K_DNC  = 14'b00000000000010;
    localparam logic [13:0] K_TNF  = 14'b00000000000001;

    logic        clk;
    logic        rst_n;
    logic [18:0] ac;
    logic [18:0] dr;
    logic [13:0] op_vec;
    logic [18:0] alu_op;
    logic        ovf_flag;

    int test_count;
    int fail_count;

    alu_19bit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .AC       (ac),
        .DR       (dr),
        .ADD      (op_vec[13]),
        .SUB      (op_vec[12]),
        .MUL      (op_vec[11]),
        .DIV      (op_vec[10]),
        .AND      (op_vec[9]),
        .OR       (op_vec[8]),
        .XOR      (op_vec[7]),
        .NOT      (op_vec[6]),
        .INC      (op_vec[5]),
        .DEC      (op_vec[4]),
        .FFT      (op_vec[3]),
        .ENC      (op_vec[2]),
        .DNC      (op_vec[1]),
        .TNF      (op_vec[0]),
        .ALU_OP   (alu_op),
        .OVF_FLAG (ovf_flag)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [18:0] actual, input logic [18:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic checkResult(input string tag, input logic [18:0] exp_op, input logic exp_ovf);
        checkOutput({tag, ".op"}, alu_op, exp_op);
        checkOutput({tag, ".ovf"}, {18'd0, ovf_flag}, {18'd0, exp_ovf});
    endtask

    // Drive on the falling edge, then sample just after the next rising edge.
    task automatic applyStimulus(input logic [18:0] a, input logic [18:0] b, input logic [13:0] ops);
        @(negedge clk);
        ac     = a;
        dr     = b;
        op_vec = ops;
        @(posedge clk);
        #1;
    endtask

    // Stimulus sequence.
    initial begin
        test_count = 0;
        fail_count = 0;
        rst_n  = 1'b0;
        ac     = 19'd1;
        dr     = 19'd2;
        op_vec = K_ADD;

        #12;
        checkResult("reset_hold", 19'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkResult("reset_release_add", 19'd3, 1'b0);

        // Asynchronous reset in the middle of a cycle clears outputs at once.
        #2;
        rst_n = 1'b0;
        #1;
        checkResult("reset_midop", 19'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(19'd262142, 19'd7, K_ADD); checkResult("add_pos_ovf", 19'h40005, 1'b1);
        applyStimulus(19'd262142, 19'd7, K_SUB); checkResult("sub_pos", 19'd262135, 1'b0);
        applyStimulus(19'd262142, 19'd7, K_MUL); checkResult("mul_ovf", 19'd262130, 1'b1);
        applyStimulus(19'd262142, 19'd7, K_DIV); checkResult("div_pos", 19'd37448, 1'b0);

        applyStimulus(19'h40002, 19'd262142, K_ADD); checkResult("add_cancel", 19'd0, 1'b0);
        applyStimulus(19'h40002, 19'd262142, K_SUB); checkResult("sub_neg_ovf", 19'd4, 1'b1);
        applyStimulus(19'h40002, 19'd262142, K_DIV); checkResult("div_neg", 19'h7FFFF, 1'b0);
        applyStimulus(19'h40002, 19'd0, K_DIV);      checkResult("div_zero", 19'h7FFFF, 1'b1);
        applyStimulus(19'h40000, 19'h7FFFF, K_DIV);  checkResult("div_min_neg1", 19'h40000, 1'b1);

        applyStimulus(19'h7FFFE, 19'h20000, K_ADD); checkResult("add_mixed", 19'd131070, 1'b0);
        applyStimulus(19'h7FFFE, 19'h20000, K_AND); checkResult("and", 19'h20000, 1'b0);
        applyStimulus(19'h7FFFE, 19'h20000, K_OR);  checkResult("or", 19'h7FFFE, 1'b0);
        applyStimulus(19'h7FFFE, 19'h20000, K_XOR); checkResult("xor", 19'h5FFFE, 1'b0);
        applyStimulus(19'h7FFFE, 19'h20000, K_NOT); checkResult("not", 19'd1, 1'b0);
        applyStimulus(19'h7FFFE, 19'h20000, K_INC); checkResult("inc", 19'h7FFFF, 1'b0);
        applyStimulus(19'h7FFFE, 19'h20000, K_DEC); checkResult("dec", 19'h7FFFD, 1'b0);
        applyStimulus(19'h7FFFE, 19'h20000, K_FFT); checkResult("fft", 19'h3FFFF, 1'b0);

        applyStimulus(19'h3FFFF, 19'd0, K_INC); checkResult("inc_max", 19'h40000, 1'b1);
        applyStimulus(19'h40000, 19'd0, K_DEC); checkResult("dec_min", 19'h3FFFF, 1'b1);

        applyStimulus(19'd43, 19'd0, K_ENC);    checkResult("enc", 19'd51110, 1'b0);
        applyStimulus(19'd51110, 19'd0, K_DNC); checkResult("dnc", 19'd43, 1'b0);
        applyStimulus(19'd43, 19'd0, K_TNF);    checkResult("tnf", 19'd524245, 1'b0);
        applyStimulus(19'h40000, 19'd0, K_TNF); checkResult("tnf_min", 19'h40000, 1'b1);

        applyStimulus(19'd262142, 19'd7, K_ADD | K_SUB); checkResult("prio_add_sub", 19'h40005, 1'b1);
        applyStimulus(19'd43, 19'd0, K_ENC | K_TNF);     checkResult("prio_enc_tnf", 19'd51110, 1'b0);
        applyStimulus(19'd262142, 19'd7, K_NONE);        checkResult("idle", 19'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
